// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU.
// Holds the PC, applies hazard stalls and branch redirects, and counts stalls/flushes.
module if_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] PC_STEP   = 16'd1,
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_write,
   input  logic             ifid_write,
   input  logic             branch_taken,
   input  logic [15:0]      branch_target,
   output logic [15:0]      imem_addr,
   input  logic [15:0]      imem_data,
   output logic [15:0]      pc,
   output logic [15:0]      ifid_instr,
   output logic [15:0]      ifid_pc_plus,
   output logic             ifid_valid,
   output logic [3:0]       ifid_opcode,
   output logic [3:0]       ifid_rd,
   output logic [3:0]       ifid_rs,
   output logic [3:0]       ifid_rt,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [15:0]      pc_q, pc_d;
   logic [15:0]      instr_q, instr_d;
   logic [15:0]      pc_plus_q, pc_plus_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [15:0]      pc_next_seq;

   assign pc_next_seq = pc_q + PC_STEP;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
      pc_d      = pc_q;
      instr_d   = instr_q;
      pc_plus_d = pc_plus_q;
      valid_d   = valid_q;
      stall_d   = stall_q;
      flush_d   = flush_q;

      if (branch_taken) begin
         // The redirect comes from an older instruction, so it overrides any load-use stall.
         pc_d      = branch_target;
         instr_d   = NOP_INSTR;
         pc_plus_d = 16'h0000;
         valid_d   = 1'b0;
         if (flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
      end else begin
         if (pc_write) begin
            pc_d = pc_next_seq;
         end else if (stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_W'(1);
         end
         if (ifid_write) begin
            instr_d   = imem_data;
            pc_plus_d = pc_next_seq;
            valid_d   = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments; reset is synchronous and overrides all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         pc_plus_q <= 16'h0000;
         valid_q   <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pc_plus_q <= pc_plus_d;
         valid_q   <= valid_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign ifid_instr   = instr_q;
   assign ifid_pc_plus = pc_plus_q;
   assign ifid_valid   = valid_q;
   assign ifid_opcode  = instr_q[15:12];
   assign ifid_rd      = instr_q[11:8];
   assign ifid_rs      = instr_q[7:4];
   assign ifid_rt      = instr_q[3:0];
   assign stall_count  = stall_q;
   assign flush_count  = flush_q;

endmodule
